// File: rtl/os_cmd_decoder.sv
// -----------------------------------------------------------------------------
// os_cmd_decoder
//
// Front end of the online-shopping OS controller. Assembles the serial,
// per-field valid/D stream into one complete command, checks the field order
// and hands the command to the OS FSM over a valid/ready handshake. It also
// remembers the current user id between commands.
//
// Accepted field sequences (leading [id] is the optional user id):
//   Buy (1) / Return (8) : [id] act item num id(seller)
//   Deposit (4)          : [id] act amnt
//   Check (2)            : [id] act [id(seller)]  -- the seller may arrive
//                          within CHK_WINDOW idle cycles after act
//
// Handshake: cmd_valid stays high with every cmd_* output frozen until a
// cycle where cmd_ready is also high; the command is consumed on that clock
// edge and cmd_valid drops on the next cycle. cmd_valid never depends on
// cmd_ready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   id_valid        D[7:0]  = user or seller id
//   act_valid       D[3:0]  = action
//   item_valid      D[1:0]  = item id
//   num_valid       D[5:0]  = item count
//   amnt_valid      D[15:0] = money amount
//   D               shared data bus
//   cmd_ready       OS controller accepts the held command
//   cmd_valid       command held on the cmd_* outputs
//   cmd_act .. cmd_amnt  command fields (unused fields are 0)
//   busy            command held, not yet accepted
//   proto_err       one-cycle pulse, the cycle after an input was discarded
//   cmd_count, err_count  (only with OS_DEC_STATS_EN) saturating counters of
//                   accepted commands and protocol errors
//
// Optional build macro: OS_DEC_STATS_EN
// -----------------------------------------------------------------------------
module os_cmd_decoder #(
    parameter int CHK_WINDOW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        act_valid,
    input  logic        item_valid,
    input  logic        num_valid,
    input  logic        amnt_valid,
    input  logic [15:0] D,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [3:0]  cmd_act,
    output logic [7:0]  cmd_user_id,
    output logic        cmd_user_new,
    output logic [1:0]  cmd_item,
    output logic [5:0]  cmd_num,
    output logic [7:0]  cmd_seller_id,
    output logic        cmd_has_seller,
    output logic [15:0] cmd_amnt,
    output logic        busy,
    output logic        proto_err
`ifdef OS_DEC_STATS_EN
    ,
    output logic [15:0] cmd_count,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [2:0] {
        D_IDLE,
        D_ACT,
        D_ITEM,
        D_NUM,
        D_SELLER,
        D_AMNT,
        D_CHK_WAIT,
        D_HOLD
    } state_t;

    localparam logic [3:0] CHK_LIMIT = 4'(CHK_WINDOW);

    state_t      state_q, state_d;
    logic [7:0]  user_id_q, user_id_d;
    logic        user_known_q, user_known_d;
    logic        user_new_q, user_new_d;
    logic [3:0]  act_q, act_d;
    logic [1:0]  item_q, item_d;
    logic [5:0]  num_q, num_d;
    logic [7:0]  seller_q, seller_d;
    logic        has_seller_q, has_seller_d;
    logic [15:0] amnt_q, amnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [2:0]  valid_cnt;
    logic        any_valid;
    logic        one_valid;
    state_t      act_dest;
    logic        act_legal;
    logic        hold;

    // A field is only taken when exactly one valid is high.
    assign valid_cnt = 3'(id_valid) + 3'(act_valid) + 3'(item_valid)
                     + 3'(num_valid) + 3'(amnt_valid);
    assign any_valid = (valid_cnt != 3'd0);
    assign one_valid = (valid_cnt == 3'd1);

    // Where a freshly sampled action leads; D_IDLE marks an illegal action.
    always_comb begin
        act_dest = D_IDLE;
        case (D[3:0])
            4'd1, 4'd8: act_dest = D_ITEM;
            4'd4:       act_dest = D_AMNT;
            4'd2:       act_dest = D_CHK_WAIT;
            default:    act_dest = D_IDLE;
        endcase
    end
    assign act_legal = (act_dest != D_IDLE);

    // Next-state and datapath.
    always_comb begin
        state_d      = state_q;
        user_id_d    = user_id_q;
        user_known_d = user_known_q;
        user_new_d   = user_new_q;
        act_d        = act_q;
        item_d       = item_q;
        num_d        = num_q;
        seller_d     = seller_q;
        has_seller_d = has_seller_q;
        amnt_d       = amnt_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;

        case (state_q)
            D_IDLE: begin
                if (any_valid) begin
                    if (one_valid && id_valid) begin
                        user_id_d  = D[7:0];
                        user_new_d = 1'b1;
                        state_d    = D_ACT;
                    end else if (one_valid && act_valid && act_legal && user_known_q) begin
                        // Start a new command: unused fields must read as 0.
                        act_d        = D[3:0];
                        item_d       = '0;
                        num_d        = '0;
                        seller_d     = '0;
                        has_seller_d = 1'b0;
                        amnt_d       = '0;
                        cnt_d        = '0;
                        state_d      = act_dest;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            D_ACT: begin
                // The announced user id survives an abort here.
                if (any_valid) begin
                    if (one_valid && act_valid && act_legal) begin
                        act_d        = D[3:0];
                        item_d       = '0;
                        num_d        = '0;
                        seller_d     = '0;
                        has_seller_d = 1'b0;
                        amnt_d       = '0;
                        cnt_d        = '0;
                        state_d      = act_dest;
                    end else begin
                        err_d   = 1'b1;
                        state_d = D_IDLE;
                    end
                end
            end

            D_ITEM: begin
                if (any_valid) begin
                    if (one_valid && item_valid) begin
                        item_d  = D[1:0];
                        state_d = D_NUM;
                    end else begin
                        err_d   = 1'b1;
                        state_d = D_IDLE;
                    end
                end
            end

            D_NUM: begin
                if (any_valid) begin
                    if (one_valid && num_valid) begin
                        num_d   = D[5:0];
                        state_d = D_SELLER;
                    end else begin
                        err_d   = 1'b1;
                        state_d = D_IDLE;
                    end
                end
            end

            D_SELLER: begin
                if (any_valid) begin
                    if (one_valid && id_valid) begin
                        seller_d     = D[7:0];
                        has_seller_d = 1'b1;
                        state_d      = D_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = D_IDLE;
                    end
                end
            end

            D_AMNT: begin
                if (any_valid) begin
                    if (one_valid && amnt_valid) begin
                        amnt_d  = D;
                        state_d = D_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = D_IDLE;
                    end
                end
            end

            D_CHK_WAIT: begin
                if (cnt_q == CHK_LIMIT) begin
                    // Window closed: issue the Check without a seller. Any
                    // field arriving on this cycle is too late and dropped.
                    state_d = D_HOLD;
                    err_d   = any_valid;
                end else if (any_valid) begin
                    if (one_valid && id_valid) begin
                        seller_d     = D[7:0];
                        has_seller_d = 1'b1;
                        state_d      = D_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = D_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            D_HOLD: begin
                // Inputs are dropped while a command is held; hold continues.
                err_d = any_valid;
                if (cmd_ready) begin
                    user_known_d = 1'b1;
                    user_new_d   = 1'b0;
                    state_d      = D_IDLE;
                end
            end

            default: state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= D_IDLE;
            user_id_q    <= '0;
            user_known_q <= 1'b0;
            user_new_q   <= 1'b0;
            act_q        <= '0;
            item_q       <= '0;
            num_q        <= '0;
            seller_q     <= '0;
            has_seller_q <= 1'b0;
            amnt_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            user_id_q    <= user_id_d;
            user_known_q <= user_known_d;
            user_new_q   <= user_new_d;
            act_q        <= act_d;
            item_q       <= item_d;
            num_q        <= num_d;
            seller_q     <= seller_d;
            has_seller_q <= has_seller_d;
            amnt_q       <= amnt_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    // Command fields are only presented while a command is held.
    assign hold           = (state_q == D_HOLD);
    assign cmd_valid      = hold;
    assign busy           = hold;
    assign cmd_act        = hold ? act_q        : '0;
    assign cmd_user_id    = hold ? user_id_q    : '0;
    assign cmd_user_new   = hold & user_new_q;
    assign cmd_item       = hold ? item_q       : '0;
    assign cmd_num        = hold ? num_q        : '0;
    assign cmd_seller_id  = hold ? seller_q     : '0;
    assign cmd_has_seller = hold & has_seller_q;
    assign cmd_amnt       = hold ? amnt_q       : '0;
    assign proto_err      = err_q;

`ifdef OS_DEC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_count <= '0;
            err_count <= '0;
        end else begin
            if (hold && cmd_ready && (cmd_count != 16'hFFFF))
                cmd_count <= cmd_count + 16'd1;
            if (err_d && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_os_cmd_decoder.sv
module tb_os_cmd_decoder;

  localparam int CHK_WINDOW = 4;
  localparam int VW = 46;
  localparam int K_ID = 0, K_ACT = 1, K_ITEM = 2, K_NUM = 3, K_AMNT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        id_valid = 0, act_valid = 0, item_valid = 0, num_valid = 0, amnt_valid = 0;
  logic [15:0] D = '0;
  logic        cmd_ready = 0;
  logic        cmd_valid;
  logic [3:0]  cmd_act;
  logic [7:0]  cmd_user_id;
  logic        cmd_user_new;
  logic [1:0]  cmd_item;
  logic [5:0]  cmd_num;
  logic [7:0]  cmd_seller_id;
  logic        cmd_has_seller;
  logic [15:0] cmd_amnt;
  logic        busy;
  logic        proto_err;
`ifdef OS_DEC_STATS_EN
  logic [15:0] cmd_count;
  logic [7:0]  err_count;
`endif

  os_cmd_decoder #(.CHK_WINDOW(CHK_WINDOW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .act_valid(act_valid), .item_valid(item_valid),
    .num_valid(num_valid), .amnt_valid(amnt_valid), .D(D),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_act(cmd_act),
    .cmd_user_id(cmd_user_id), .cmd_user_new(cmd_user_new), .cmd_item(cmd_item),
    .cmd_num(cmd_num), .cmd_seller_id(cmd_seller_id), .cmd_has_seller(cmd_has_seller),
    .cmd_amnt(cmd_amnt), .busy(busy), .proto_err(proto_err)
`ifdef OS_DEC_STATS_EN
    , .cmd_count(cmd_count), .err_count(err_count)
`endif
  );

  logic [VW-1:0] out_vec;
  assign out_vec = {cmd_act, cmd_user_id, cmd_user_new, cmd_item, cmd_num,
                    cmd_seller_id, cmd_has_seller, cmd_amnt};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [7:0]    m_user;
  bit            m_known, m_new;
  int            m_errs = 0, m_errs_sr = 0, m_cmds = 0, m_cmds_sr = 0;
  logic [VW-1:0] exp_q[$];
  int            seen_err = 0, seen_cmd = 0;

  // Expected command as the OS controller should see it.
  function automatic logic [VW-1:0] make_vec(input logic [3:0] act, input logic [7:0] user,
                                              input bit unew, input logic [1:0] item,
                                              input logic [5:0] num, input logic [7:0] seller,
                                              input bit has, input logic [15:0] amnt);
    bit is_br, is_dep, is_chk;
    is_br  = (act == 4'd1) || (act == 4'd8);
    is_dep = (act == 4'd4);
    is_chk = (act == 4'd2);
    return {act, user, unew,
            is_br ? item : 2'b0,
            is_br ? num : 6'b0,
            (is_br || (is_chk && has)) ? seller : 8'b0,
            is_br ? 1'b1 : (is_chk ? has : 1'b0),
            is_dep ? amnt : 16'b0};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (proto_err) seen_err++;
      if (cmd_valid && cmd_ready) begin
        seen_cmd++;
        check_eq("exp_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("cmd", out_vec, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drive_beat(input int k, input logic [15:0] d);
    id_valid   = (k == K_ID);
    act_valid  = (k == K_ACT);
    item_valid = (k == K_ITEM);
    num_valid  = (k == K_NUM);
    amnt_valid = (k == K_AMNT);
    D = d;
    cyc();
    id_valid = 0; act_valid = 0; item_valid = 0; num_valid = 0; amnt_valid = 0;
    D = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1;
    cmd_ready = 0;
    cyc();
    rst = 0;
    m_user = '0; m_known = 0; m_new = 0;
    m_errs_sr = 0; m_cmds_sr = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, cmd_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err"}, proto_err, 0);
    check_eq({tag, "_fields"}, out_vec, '0);
  endtask

  task automatic note_err(input string tag);
    m_errs++; m_errs_sr++;
    check_eq(tag, proto_err, 1);
    check_eq({tag, "_novalid"}, cmd_valid, 0);
  endtask

  task automatic err_act(input logic [3:0] a);
    drive_beat(K_ACT, {12'h0, a});
    note_err("err_act");
  endtask

  task automatic err_double();
    act_valid = 1; item_valid = 1; D = 16'h0001;
    cyc();
    act_valid = 0; item_valid = 0;
    note_err("err_double");
  endtask

  task automatic err_id_then_item(input logic [7:0] uid);
    drive_beat(K_ID, {8'h0, uid});
    m_user = uid; m_new = 1;
    drive_beat(K_ITEM, 16'h0002);
    note_err("err_id_item");
  endtask

  task automatic run_cmd(input bit with_id, input logic [7:0] uid, input logic [3:0] act,
                         input logic [1:0] item, input logic [5:0] num,
                         input logic [7:0] seller, input bit has, input int gap,
                         input logic [15:0] amnt, input int rdly, input bit inj);
    logic [VW-1:0] exp;
    int lat, exp_lat;
    bit seen;
    if (with_id) begin m_user = uid; m_new = 1; end
    exp = make_vec(act, m_user, m_new, item, num, seller, has, amnt);
    exp_q.push_back(exp);
    if (with_id) begin drive_beat(K_ID, {8'h0, uid}); idle(gap); end
    drive_beat(K_ACT, {12'h0, act});
    if (act == 4'd1 || act == 4'd8) begin
      idle(gap); drive_beat(K_ITEM, {14'h0, item});
      idle(gap); drive_beat(K_NUM, {10'h0, num});
      idle(gap); drive_beat(K_ID, {8'h0, seller});
    end else if (act == 4'd4) begin
      idle(gap); drive_beat(K_AMNT, amnt);
    end else if (has) begin
      idle(gap); drive_beat(K_ID, {8'h0, seller});
    end
    exp_lat = (act == 4'd2 && !has) ? CHK_WINDOW + 1 : 0;
    lat = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_valid) begin seen = 1; break; end
      cyc();
      lat++;
    end
    check_eq("cmd_seen", seen, 1);
    check_eq("latency", lat, exp_lat);
    for (int i = 0; i < rdly; i++) begin
      if (inj && i == 0) begin
        drive_beat(K_AMNT, 16'($urandom));
        m_errs++; m_errs_sr++;
        check_eq("hold_err", proto_err, 1);
      end else begin
        cyc();
      end
      check_eq("hold_busy", busy, 1);
      check_eq("hold_stable", out_vec, exp);
    end
    cmd_ready = 1;
    cyc();
    cmd_ready = 0;
    m_known = 1; m_new = 0; m_cmds++; m_cmds_sr++;
    check_eq("valid_drop", cmd_valid, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a;
    int r, g;
    bit h;
    do_reset();
    check_idle_outputs("reset");

    // Action before any user is known.
    err_act(4'd1);
    // Buy with new user, immediate accept.
    run_cmd(1, 8'h12, 4'd1, 2'd2, 6'd5, 8'h40, 1, 0, 16'h0, 0, 0);
    // Deposit without id, ready held low 3 cycles.
    run_cmd(0, 8'h00, 4'd4, 2'd0, 6'd0, 8'h00, 0, 0, 16'h0100, 3, 0);
    // Check, window expires.
    run_cmd(0, 8'h00, 4'd2, 2'd0, 6'd0, 8'h00, 0, 0, 16'h0, 0, 0);
    // Check, seller two cycles after act.
    run_cmd(0, 8'h00, 4'd2, 2'd0, 6'd0, 8'h33, 1, 2, 16'h0, 1, 0);
    err_double();
    err_act(4'd3);
    err_act(4'd0);
    // Valid during hold is dropped.
    run_cmd(1, 8'h21, 4'd8, 2'd1, 6'd63, 8'h7E, 1, 1, 16'h0, 2, 1);

    // Reset in the middle of a Buy (in the item-count stage).
    drive_beat(K_ID, 16'h0055);
    drive_beat(K_ACT, 16'h0001);
    drive_beat(K_ITEM, 16'h0001);
    do_reset();
    check_idle_outputs("mid_reset");
    err_act(4'd1);
    run_cmd(1, 8'h61, 4'd4, 2'd0, 6'd0, 8'h00, 0, 1, 16'hBEEF, 0, 0);
    run_cmd(0, 8'h00, 4'd1, 2'd3, 6'd9, 8'h02, 1, 0, 16'h0, 1, 0);
`ifdef OS_DEC_STATS_EN
    check_eq("cmd_count", cmd_count, 2);
    check_eq("err_count", err_count, 1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do a = 4'($urandom); while (a == 4'd1 || a == 4'd2 || a == 4'd4 || a == 4'd8);
        err_act(a);
      end else if (r == 1) begin
        err_double();
      end else if (r == 2) begin
        err_id_then_item(8'($urandom));
      end else begin
        case ($urandom_range(0, 3))
          0: a = 4'd1;
          1: a = 4'd8;
          2: a = 4'd4;
          default: a = 4'd2;
        endcase
        h = 1'($urandom_range(0, 1));
        g = (a == 4'd2) ? $urandom_range(0, CHK_WINDOW - 1) : $urandom_range(0, 2);
        run_cmd(!m_known || ($urandom_range(0, 1) == 1), 8'($urandom), a,
                2'($urandom), 6'($urandom), 8'($urandom), h, g, 16'($urandom),
                $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      end
      idle($urandom_range(0, 2));
    end

    idle(2);
    check_eq("err_total", seen_err, m_errs);
    check_eq("cmd_total", seen_cmd, m_cmds);
    check_eq("exp_q_empty", exp_q.size(), 0);
`ifdef OS_DEC_STATS_EN
    check_eq("cmd_count_end", cmd_count, m_cmds_sr);
    check_eq("err_count_end", err_count, m_errs_sr);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
